// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: sequential PC generation feeding a small prefetch FIFO,
// with redirect/flush and a fault state for out-of-range fetch addresses.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_HEIGHT = 256,
    parameter int          DEPTH      = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Start,
    output logic [31:0] o_Mem_Addr,
    input  logic [31:0] i_Mem_Data,
    output logic        o_Valid,
    output logic [31:0] o_Instruction,
    output logic [31:0] o_PC,
    input  logic        i_Ready,
    input  logic        i_Redirect,
    input  logic [31:0] i_Redirect_PC,
    output logic        o_Fault,
    output logic        o_Busy
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] LAST_PC = 32'(MEM_HEIGHT - 4);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

    state_t        r_State, w_Next_State;
    logic [31:0]   r_Pc, w_Pc_Next, w_Pc_Plus4;
    logic [31:0]   r_Instr_Mem [DEPTH];
    logic [31:0]   r_Pc_Mem    [DEPTH];
    logic [AW-1:0] r_Wr_Ptr, r_Rd_Ptr;
    logic [AW:0]   r_Count;
    logic [31:0]   r_Last_Instr, r_Last_Pc;
    logic          w_Valid, w_Full, w_Pop, w_Fetch;

    function automatic logic f_Legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc <= LAST_PC);
    endfunction

    assign w_Valid    = (r_Count != '0);
    assign w_Full     = (r_Count == (AW+1)'(DEPTH));
    assign w_Pop      = w_Valid && i_Ready && !i_Redirect;
    assign w_Fetch    = (r_State == S_RUN) && !i_Redirect && f_Legal(r_Pc) && (!w_Full || w_Pop);
    assign w_Pc_Plus4 = r_Pc + 32'd4;

    always_comb begin
        w_Next_State = r_State;
        w_Pc_Next    = r_Pc;
        if (i_Redirect) begin
            if (f_Legal(i_Redirect_PC)) begin
                w_Next_State = S_RUN;
                w_Pc_Next    = i_Redirect_PC;
            end else begin
                w_Next_State = S_FAULT;
            end
        end else begin
            case (r_State)
                S_IDLE: begin
                    if (i_Start) begin
                        w_Pc_Next    = RESET_PC;
                        w_Next_State = f_Legal(RESET_PC) ? S_RUN : S_FAULT;
                    end
                end
                S_RUN: begin
                    if (!f_Legal(r_Pc)) begin
                        w_Next_State = S_FAULT;
                    end else if (w_Fetch) begin
                        w_Pc_Next = w_Pc_Plus4;
                        // Leave RUN as soon as the advanced PC runs off the end of memory.
                        if (!f_Legal(w_Pc_Plus4)) w_Next_State = S_FAULT;
                    end
                end
                default: w_Next_State = S_FAULT;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State <= S_IDLE;
            r_Pc    <= RESET_PC;
        end else begin
            r_State <= w_Next_State;
            r_Pc    <= w_Pc_Next;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Wr_Ptr     <= '0;
            r_Rd_Ptr     <= '0;
            r_Count      <= '0;
            r_Last_Instr <= '0;
            r_Last_Pc    <= '0;
        end else if (i_Redirect) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
            r_Count  <= '0;
            if (w_Valid) begin
                r_Last_Instr <= r_Instr_Mem[r_Rd_Ptr];
                r_Last_Pc    <= r_Pc_Mem[r_Rd_Ptr];
            end
        end else begin
            if (w_Fetch) r_Wr_Ptr <= r_Wr_Ptr + AW'(1);
            if (w_Pop) begin
                r_Rd_Ptr     <= r_Rd_Ptr + AW'(1);
                r_Last_Instr <= r_Instr_Mem[r_Rd_Ptr];
                r_Last_Pc    <= r_Pc_Mem[r_Rd_Ptr];
            end
            case ({w_Fetch, w_Pop})
                2'b10:   r_Count <= r_Count + (AW+1)'(1);
                2'b01:   r_Count <= r_Count - (AW+1)'(1);
                default: r_Count <= r_Count;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (w_Fetch) begin
            r_Instr_Mem[r_Wr_Ptr] <= i_Mem_Data;
            r_Pc_Mem[r_Wr_Ptr]    <= r_Pc;
        end
    end

    // An empty FIFO shows the most recently departed head rather than stale storage.
    assign o_Valid       = w_Valid;
    assign o_Instruction = w_Valid ? r_Instr_Mem[r_Rd_Ptr] : r_Last_Instr;
    assign o_PC          = w_Valid ? r_Pc_Mem[r_Rd_Ptr]    : r_Last_Pc;
    assign o_Mem_Addr    = r_Pc;
    assign o_Busy        = (r_State == S_RUN);
    assign o_Fault       = (r_State == S_FAULT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: expected PCs queued at stimulus time, popped on each handshake.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    assign mem_data = mem_word(mem_addr);

    instr_fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .MEM_HEIGHT(256),
        .DEPTH     (2)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_Start      (start),
        .o_Mem_Addr   (mem_addr),
        .i_Mem_Data   (mem_data),
        .o_Valid      (valid),
        .o_Instruction(instr),
        .o_PC         (pc),
        .i_Ready      (ready),
        .i_Redirect   (redirect),
        .i_Redirect_PC(redirect_pc),
        .o_Fault      (fault),
        .o_Busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Handshake monitor: every accepted head must be the next queued PC.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rst_n && valid && ready && !redirect) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_delivery", pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("deliv_pc", pc, e);
                chk("deliv_instr", instr, mem_word(e));
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #2;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_mem_addr", mem_addr, 0);
        step();
        rst_n = 1'b1;
        step();

        // Continuous consumption from start: 0,4,8 back to back.
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("start_valid_lat", 32'(valid), 0);
        chk("start_busy", 32'(busy), 1);
        chk("start_mem_addr", mem_addr, 0);
        step();
        chk("first_valid", 32'(valid), 1);
        step(3);
        ready = 1'b0;
        chk("A_q_empty", 32'(exp_q.size()), 0);
        step(3);
        chk("A_full_head", pc, 32'hC);
        chk("A_full_addr", mem_addr, 32'h14);

        // Asynchronous reset between edges with a full FIFO.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(valid), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_addr", mem_addr, 0);
        chk("async_pc", pc, 0);
        step();
        rst_n = 1'b1;
        step(2);
        chk("idle_no_fetch_valid", 32'(valid), 0);
        chk("idle_no_fetch_addr", mem_addr, 0);

        // Backpressure: exactly DEPTH entries, head stable, address parked.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_head_pc", pc, 0);
        end
        chk("stall_valid", 32'(valid), 1);
        chk("stall_instr", instr, mem_word(32'h0));
        chk("stall_addr", mem_addr, 32'h8);

        // Redirect with buffered entries and a concurrent pop: nothing old delivered.
        exp_q.push_back(32'h40); exp_q.push_back(32'h44);
        redirect = 1'b1; redirect_pc = 32'h40; ready = 1'b1;
        step();
        redirect = 1'b0;
        chk("redir_flush_valid", 32'(valid), 0);
        chk("redir_busy", 32'(busy), 1);
        step();
        chk("redir_valid", 32'(valid), 1);
        step(2);
        ready = 1'b0;
        chk("redir_q_empty", 32'(exp_q.size()), 0);
        step(2);

        // Illegal redirects land in FAULT; start is ignored there.
        redirect = 1'b1; redirect_pc = 32'h42;
        step();
        redirect = 1'b0;
        chk("misalign_fault", 32'(fault), 1);
        chk("misalign_busy", 32'(busy), 0);
        chk("misalign_valid", 32'(valid), 0);
        step(3);
        chk("fault_no_fetch_valid", 32'(valid), 0);
        chk("fault_addr_held", mem_addr, 32'h50);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("fault_start_ignored", 32'(fault), 1);
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("oob_fault", 32'(fault), 1);
        chk("oob_valid", 32'(valid), 0);
        chk("oob_addr_held", mem_addr, 32'h50);

        // Legal redirect out of FAULT, then stream to the end of memory.
        for (int a = 32'h10; a <= 32'hFC; a += 4) exp_q.push_back(32'(a));
        redirect = 1'b1; redirect_pc = 32'h10; ready = 1'b1;
        step();
        redirect = 1'b0;
        chk("recover_busy", 32'(busy), 1);
        chk("recover_fault", 32'(fault), 0);
        for (int i = 0; i < 100 && !fault; i++) step();
        chk("end_fault", 32'(fault), 1);
        step();
        chk("end_valid", 32'(valid), 0);
        chk("end_addr", mem_addr, 32'h100);
        chk("end_q_empty", 32'(exp_q.size()), 0);
        step(2);
        chk("end_addr_held", mem_addr, 32'h100);
        ready = 1'b0;

        // Redirect from IDLE acts as a start at the target.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        exp_q.push_back(32'h20);
        redirect = 1'b1; redirect_pc = 32'h20;
        step();
        redirect = 1'b0;
        ready = 1'b1;
        chk("idle_redir_busy", 32'(busy), 1);
        step();
        step();
        ready = 1'b0;
        chk("idle_redir_q_empty", 32'(exp_q.size()), 0);
        chk("idle_redir_head", pc, 32'h24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
